// File: rtl/retire_map_table.sv
// Committed (architectural) register map at the retire end of rename.
// Each retiring instruction with a real destination releases the phys reg
// it displaces back to the free list and becomes the committed mapping.
// free_reg entry layout: bits [PW:1] = reg_idx, bit 0 = valid.
module retire_map_table #(
    parameter int N         = 2,
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    localparam int CW = $clog2(N + 1),
    localparam int AW = $clog2(ARCH_REGS),
    localparam int PW = $clog2(PHYS_REGS)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [CW-1:0]                 retire_num,
    input  logic [N-1:0][AW-1:0]          retire_arch,
    input  logic [N-1:0][PW-1:0]          retire_phys,
    output logic [CW-1:0]                 free_num,
    output logic [N-1:0][PW:0]            free_reg,
    output logic [ARCH_REGS-1:0][PW-1:0]  arch_map
);

    logic [ARCH_REGS-1:0][PW-1:0] work_map;
    logic [N-1:0][PW:0]           next_free;
    logic [CW-1:0]                next_num;
    logic [CW-1:0]                eff_num;
    logic [PW-1:0]                old_phys;

    // Walk slots in program order against a working copy of the map so a
    // later slot sees an earlier slot's write to the same arch reg, packing
    // displaced regs into the low free slots with no gaps.
    always_comb begin
        work_map  = arch_map;
        next_free = '0;
        next_num  = '0;
        old_phys  = '0;
        eff_num   = (retire_num > CW'(N)) ? CW'(N) : retire_num;
        for (int i = 0; i < N; i++) begin
            if ((CW'(i) < eff_num) && (retire_arch[i] != '0) && (retire_phys[i] != '0)) begin
                old_phys                 = work_map[retire_arch[i]];
                next_free[next_num]      = {old_phys, 1'b1};
                next_num                 = next_num + CW'(1);
                work_map[retire_arch[i]] = retire_phys[i];
            end
        end
        work_map[0] = '0;
    end

    // Register the committed map and this cycle's frees; reset restores the
    // identity map (matching the free list's initial contents) and drops
    // anything retiring in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                arch_map[i] <= PW'(i);
            end
            free_num <= '0;
            free_reg <= '0;
        end else begin
            arch_map <= work_map;
            free_num <= next_num;
            free_reg <= next_free;
        end
    end

endmodule

// File: tb/tb_retire_map_table.sv
// Directed bench for retire_map_table with N=2, ARCH_REGS=32, PHYS_REGS=64.
// Expected frees and map contents are hand-computed per step; a small
// scoreboard of freed regs checks that no phys reg is held twice.
module tb_retire_map_table;

    logic              clock = 1'b0;
    logic              reset;
    logic [1:0]        retire_num;
    logic [1:0][4:0]   retire_arch;
    logic [1:0][5:0]   retire_phys;
    logic [1:0]        free_num;
    logic [1:0][6:0]   free_reg;
    logic [31:0][5:0]  arch_map;

    int total = 0;
    int bad   = 0;
    int model_map [32];
    bit freed [64];

    retire_map_table #(.N(2), .ARCH_REGS(32), .PHYS_REGS(64)) dut (
        .clock       (clock),
        .reset       (reset),
        .retire_num  (retire_num),
        .retire_arch (retire_arch),
        .retire_phys (retire_phys),
        .free_num    (free_num),
        .free_reg    (free_reg),
        .arch_map    (arch_map)
    );

    always #5 clock = ~clock;

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model_map[i] = i;
        for (int i = 0; i < 64; i++) freed[i] = 1'b0;
    endtask

    task automatic apply_stimulus(input int num, input int a0, input int p0, input int a1, input int p1);
        retire_num     = 2'(num);
        retire_arch[0] = 5'(a0);
        retire_phys[0] = 6'(p0);
        retire_arch[1] = 5'(a1);
        retire_phys[1] = 6'(p1);
        @(posedge clock);
        #1;
        retire_num = 2'd0;
    endtask

    task automatic idle_cycle();
        retire_num = 2'd0;
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string tag, input int exp_num, input int r0, input int r1);
        logic [6:0] e0;
        logic [6:0] e1;
        e0 = (exp_num > 0) ? {6'(r0), 1'b1} : 7'd0;
        e1 = (exp_num > 1) ? {6'(r1), 1'b1} : 7'd0;
        check({tag, "_num"}, 64'(free_num), 64'(exp_num));
        check({tag, "_reg0"}, 64'(free_reg[0]), 64'(e0));
        check({tag, "_reg1"}, 64'(free_reg[1]), 64'(e1));
        if (exp_num > 0) freed[r0] = 1'b1;
        if (exp_num > 1) freed[r1] = 1'b1;
    endtask

    task automatic check_map(input string tag);
        int wrong;
        int dup;
        bit seen [64];
        wrong = 0;
        dup   = 0;
        for (int i = 0; i < 64; i++) seen[i] = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (int'(arch_map[i]) != model_map[i]) begin
                if (wrong == 0)
                    $display("[TB] %s first differing entry arch=%0d observed=%0d expected=%0d",
                             tag, i, arch_map[i], model_map[i]);
                wrong++;
            end
            if (seen[arch_map[i]]) dup++;
            seen[arch_map[i]] = 1'b1;
        end
        for (int p = 0; p < 64; p++) begin
            if (freed[p] && seen[p]) dup++;
        end
        check({tag, "_map_entries_wrong"}, 64'(wrong), 64'd0);
        check({tag, "_duplicates"}, 64'(dup), 64'd0);
    endtask

    initial begin
        reset       = 1'b1;
        retire_num  = '0;
        retire_arch = '0;
        retire_phys = '0;
        model_reset();

        // Reset held one cycle then released.
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_output("reset", 0, 0, 0);
        check_map("reset");

        // Single retirement, then idle.
        apply_stimulus(1, 3, 40, 0, 0);
        check_output("single", 1, 3, 0);
        model_map[3] = 40;
        check_map("single");
        idle_cycle();
        check_output("single_idle", 0, 0, 0);

        // Same arch reg twice in one group: second slot frees the first's phys.
        apply_stimulus(2, 7, 33, 7, 34);
        check_output("fwd", 2, 7, 33);
        model_map[7] = 34;
        check_map("fwd");

        // Arch 0 slot ignored and compacted out.
        apply_stimulus(2, 0, 50, 4, 51);
        check_output("zero_arch", 1, 4, 0);
        model_map[4] = 51;
        check_map("zero_arch");

        // retire_num above N clamps to N.
        apply_stimulus(3, 8, 52, 9, 53);
        check_output("clamp", 2, 8, 9);
        model_map[8] = 52;
        model_map[9] = 53;
        check_map("clamp");

        // Phys 0 slot ignored.
        apply_stimulus(2, 10, 0, 11, 54);
        check_output("zero_phys", 1, 11, 0);
        model_map[11] = 54;
        check_map("zero_phys");

        // Fresh start for the back-to-back case.
        reset = 1'b1;
        idle_cycle();
        reset = 1'b0;
        model_reset();
        check_output("rereset", 0, 0, 0);
        check_map("rereset");

        // Back-to-back retirements to the same arch reg across cycles.
        apply_stimulus(1, 3, 40, 0, 0);
        check_output("b2b_a", 1, 3, 0);
        apply_stimulus(1, 3, 41, 0, 0);
        check_output("b2b_b", 1, 40, 0);
        model_map[3] = 41;
        check_map("b2b");

        // Reset wins over retirements in the same cycle.
        reset = 1'b1;
        apply_stimulus(2, 5, 45, 6, 46);
        reset = 1'b0;
        model_reset();
        check_output("reset_prio", 0, 0, 0);
        check_map("reset_prio");
        check("reset_prio_map5", 64'(arch_map[5]), 64'd5);
        check("reset_prio_map6", 64'(arch_map[6]), 64'd6);
        idle_cycle();
        check_output("final_idle", 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/retire_map_table.md
Name: retire_map_table

Overview:
Committed (architectural) register map table at the retire end of the rename/free-list protocol. Each cycle it accepts up to N retiring instructions, each carrying an arch dest reg and its new phys reg. For each one it releases the previously committed phys reg back to the free list through the free list's wr_num/wr_reg write interface. It also holds the committed arch->phys map, which recovery logic uses to rebuild the speculative map table.

Parameters:
N, `N, max retirements per cycle and max frees per cycle
ARCH_REGS, `ARCH_REG_SZ, number of architectural registers; index 0 is the hardwired zero reg
PHYS_REGS, `ARCH_REG_SZ+`ROB_SZ, number of physical registers; PW = $clog2(PHYS_REGS)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
retire_num  in  $clog2(N+1)  number of valid retire slots this cycle, slots 0..retire_num-1, in program order
retire_arch  in  N x $clog2(ARCH_REGS)  arch dest reg per slot; 0 = no destination
retire_phys  in  N x PW  new phys reg committed per slot
free_num  out  $clog2(N+1)  count of regs being freed; drives the free list wr_num
free_reg  out  FREE_LIST_PACKET[N]  freed regs, compacted into slots 0..free_num-1; drives the free list wr_reg
arch_map  out  ARCH_REGS x PW  committed map table, registered

Behaviour:
- Reset: arch_map[i] = i for all i. This matches the free list reset contents (ARCH_REGS..PHYS_REGS-1). free_num = 0; free_reg all zero.
- Clock and reset: reset is synchronous and active-high on clock; all state is updated on posedge clock.
- Clamping: effective count = min(retire_num, N).
- Slot processing, combinational, slot order 0..N-1, for each slot i < effective count:
  - arch == 0 or phys == 0: slot is ignored. No free, no map write.
  - Otherwise: old = working_map[arch], where working_map is the registered map plus updates from earlier slots in the same cycle. This intra-group forwarding is mandatory.
  - The slot emits old as a freed reg, then sets working_map[arch] = phys.
- Compaction: freed regs are packed in slot order into free_reg[0..k-1] with valid = 1. Entries k..N-1 are zero. free_num = k. Ignored slots leave no gaps.
- Latency: exactly 1 cycle. free_num/free_reg and arch_map are registered, so they reflect cycle t's retirements during cycle t+1.
- Idle: with no retirement (effective count 0), free_num = 0 and free_reg = 0 on the next cycle. A free is never re-emitted.
- Zero reg: arch_map[0] is never written and stays 0. phys reg 0 is never emitted as a free.
- No back-pressure: the free list always accepts up to N writes per cycle. This block has no stall output.
- Reset mid-operation: reset has priority over retire inputs in the same cycle. The map returns to identity, outputs clear, and in-flight retirements are dropped.
- Frees per cycle never exceed N, because each valid slot frees exactly one reg.
- Invariant: the set {arch_map} ∪ {regs already freed} never contains duplicates. The bench checks this with a scoreboard.

Test Plan (N=2, ARCH_REGS=32, PHYS_REGS=64):
1. Reset held 1 cycle, then released -> arch_map[i] = i for all i, free_num = 0, free_reg = 0.
2. retire_num=1, arch=3, phys=40 -> next cycle: free_num=1, free_reg[0]={reg_idx 3, valid 1}, arch_map[3]=40; the cycle after: free_num=0.
3. retire_num=2, slot0 {arch 7, phys 33}, slot1 {arch 7, phys 34} -> free_num=2, free_reg[0]=7, free_reg[1]=33, arch_map[7]=34.
4. retire_num=2, slot0 {arch 0, phys 50}, slot1 {arch 4, phys 51} -> free_num=1, free_reg[0]=4 (compacted), free_reg[1]=0, arch_map[4]=51, arch_map[0]=0.
5. Back-to-back: cycle A {arch 3, phys 40}, cycle A+1 {arch 3, phys 41} -> at A+2: free_num=1, free_reg[0]=40, arch_map[3]=41.
6. Reset asserted in the same cycle as retire_num=2 {arch 5 phys 45, arch 6 phys 46} -> next cycle: free_num=0, arch_map[5]=5, arch_map[6]=6.
